// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, a one-entry skid
// buffer behind the IF/ID register, and redirect handling that drops any
// response belonging to a flushed fetch.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [6:0]  id_funct7
);

   localparam logic [1:0] FETCH   = 2'd0;
   localparam logic [1:0] HOLD    = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_next_seq;
   logic        id_free;

   // Word-aligned redirect target, sequential next pc, and IF/ID availability
   always_comb begin
      redirect_tgt = {redirect_pc[31:2], 2'b00};
      pc_next_seq  = pc + 32'd4;
      id_free      = !id_valid || !stall;
   end

   // Request is outstanding except while a word is parked in the skid buffer
   always_comb begin
      imem_req  = (state != HOLD);
      imem_addr = pc;
      id_funct7 = id_instr[31:25];
   end

   // Fetch state machine, pc, skid buffer and IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         pend_pc    <= 32'h0;
         skid_instr <= 32'h0;
         skid_pc    <= 32'h0;
         id_valid   <= 1'b0;
         id_instr   <= NOP;
         id_pc      <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  id_valid   <= 1'b0;
                  skid_instr <= 32'h0;
                  skid_pc    <= 32'h0;
                  if (imem_ack) begin
                     pc <= redirect_tgt;
                  end else begin
                     pend_pc <= redirect_tgt;
                     state   <= DISCARD;
                  end
               end else if (imem_ack) begin
                  pc <= pc_next_seq;
                  if (id_free) begin
                     id_valid <= 1'b1;
                     id_instr <= imem_rdata;
                     id_pc    <= pc;
                  end else begin
                     skid_instr <= imem_rdata;
                     skid_pc    <= pc;
                     state      <= HOLD;
                  end
               end else if (!stall) begin
                  id_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  id_valid   <= 1'b0;
                  skid_instr <= 32'h0;
                  skid_pc    <= 32'h0;
                  pc         <= redirect_tgt;
                  state      <= FETCH;
               end else if (!stall) begin
                  id_valid <= 1'b1;
                  id_instr <= skid_instr;
                  id_pc    <= skid_pc;
                  state    <= FETCH;
               end
            end
            DISCARD: begin
               // The in-flight response is never written into IF/ID
               if (redirect) begin
                  id_valid   <= 1'b0;
                  skid_instr <= 32'h0;
                  skid_pc    <= 32'h0;
                  pend_pc    <= redirect_tgt;
                  if (imem_ack) begin
                     pc    <= redirect_tgt;
                     state <= FETCH;
                  end
               end else begin
                  if (!stall) begin
                     id_valid <= 1'b0;
                  end
                  if (imem_ack) begin
                     pc    <= pend_pc;
                     state <= FETCH;
                  end
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a queue-based fetch model predicts the
// imem request stream and IF/ID contents cycle by cycle.
module tb_if_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [6:0]  id_funct7;

   logic        reset1;
   logic        imem_req1;
   logic [31:0] imem_addr1;
   logic        imem_ack1;
   logic [31:0] imem_rdata1;
   logic        id_valid1;
   logic [31:0] id_instr1;
   logic [31:0] id_pc1;
   logic [6:0]  id_funct71;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_drop;
   logic [31:0] m_pend;
   ent_t        skq[$];
   logic        m_v;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
      .id_instr(id_instr), .id_pc(id_pc), .id_funct7(id_funct7)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset1), .imem_req(imem_req1), .imem_addr(imem_addr1),
      .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .stall(1'b0),
      .redirect(1'b0), .redirect_pc(32'h0), .id_valid(id_valid1),
      .id_instr(id_instr1), .id_pc(id_pc1), .id_funct7(id_funct71)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_req();
      return (skq.size() == 0);
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_drop = 1'b0; m_pend = 32'h0; skq.delete();
      m_v = 1'b0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
   endtask

   // One clock edge of the fetch rules, applied to the current inputs
   task automatic model_step();
      logic [31:0] tgt;
      ent_t e;
      tgt = {redirect_pc[31:2], 2'b00};
      if (redirect) begin
         m_v = 1'b0;
         if (skq.size() != 0 || imem_ack) begin
            m_pc = tgt; m_drop = 1'b0;
         end else begin
            m_pend = tgt; m_drop = 1'b1;
         end
         skq.delete();
      end else if (skq.size() != 0) begin
         if (!stall) begin
            e = skq.pop_front();
            m_v = 1'b1; m_instr = e.instr; m_ipc = e.pc;
         end
      end else if (imem_ack && !m_drop) begin
         if (!m_v || !stall) begin
            m_v = 1'b1; m_instr = imem_rdata; m_ipc = m_pc;
         end else begin
            skq.push_back({imem_rdata, m_pc});
         end
         m_pc = m_pc + 32'd4;
      end else begin
         if (!stall) m_v = 1'b0;
         if (imem_ack) begin
            m_pc = m_pend; m_drop = 1'b0;
         end
      end
   endtask

   task automatic compare(input string ph);
      check({ph, ".req"},    {31'h0, imem_req}, {31'h0, model_req()});
      check({ph, ".addr"},   imem_addr, m_pc);
      check({ph, ".valid"},  {31'h0, id_valid}, {31'h0, m_v});
      check({ph, ".instr"},  id_instr, m_instr);
      check({ph, ".pc"},     id_pc, m_ipc);
      check({ph, ".funct7"}, {25'h0, id_funct7}, {25'h0, m_instr[31:25]});
   endtask

   // Starts and ends on a falling edge; stream mode acks every cycle
   task automatic run_cycles(input int n, input bit stream, input string ph);
      for (int i = 0; i < n; i++) begin
         if (stream) begin
            stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
            imem_ack = 1'b1;
            imem_rdata = m_pc ^ 32'hA5A5_0000;
         end else begin
            stall       = ($urandom_range(0, 9) < 4);
            redirect    = ($urandom_range(0, 99) < 8);
            redirect_pc = {20'h0, $urandom_range(0, 4095)};
            imem_ack    = model_req() && ($urandom_range(0, 9) < 6);
            imem_rdata  = $urandom;
         end
         @(posedge clk);
         model_step();
         @(negedge clk);
         compare(ph);
      end
   endtask

   initial begin
      reset = 1'b1; reset1 = 1'b1;
      imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      imem_ack1 = 1'b0; imem_rdata1 = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      compare("rst");
      check("wrap.rst_addr", imem_addr1, 32'hFFFF_FFFC);
      check("wrap.rst_req", {31'h0, imem_req1}, 32'h1);

      reset = 1'b0;
      run_cycles(20, 1'b1, "stream");
      run_cycles(1500, 1'b0, "rand");

      // asynchronous reset in the middle of a request
      imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("mid_rst.valid", {31'h0, id_valid}, 32'h0);
      check("mid_rst.addr", imem_addr, 32'h0);
      check("mid_rst.req", {31'h0, imem_req}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      run_cycles(5, 1'b1, "post_rst");
      run_cycles(500, 1'b0, "rand2");

      // wrap of pc+4 from the top of the address space
      reset1 = 1'b0;
      imem_ack1 = 1'b1; imem_rdata1 = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack1 = 1'b0;
      check("wrap.valid", {31'h0, id_valid1}, 32'h1);
      check("wrap.id_pc", id_pc1, 32'hFFFF_FFFC);
      check("wrap.instr", id_instr1, 32'hDEAD_BEEF);
      check("wrap.next_addr", imem_addr1, 32'h0);
      @(negedge clk);
      #2 reset1 = 1'b1;
      #1;
      check("wrap.rst_valid", {31'h0, id_valid1}, 32'h0);
      check("wrap.rst_addr2", imem_addr1, 32'hFFFF_FFFC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
